// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage : decode/execute pipeline register with operand forwarding.
//
// Holds one decoded instruction between decode and execute and presents
// the ALU operands, operation and store data combinationally from that
// held entry.
//
// Optional feature macro: EX_FWD_EN
//   defined   - operands are forwarded from the EX/MEM and MEM/WB producers
//               (EX/MEM wins), and held register data is refreshed with the
//               forwarded values every stalled cycle. No interlock.
//   undefined - no forwarding; decode is interlocked while a source register
//               matches the held entry's rd or the EX/MEM rd.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   id_valid / id_ready       decode-side handshake
//   id_pc, id_imm             decoded PC and immediate
//   id_rs1_data, id_rs2_data  register-file read data
//   id_rs1, id_rs2, id_rd     source / destination register indices
//   id_use_pc, id_use_imm     A operand = PC, B operand = immediate
//   id_reg_write, id_alu_op   instruction writes rd, ALU operation
//   flush                     discard held entry, block capture
//   exm_*, mwb_*              EX/MEM and MEM/WB result producers
//   ex_valid / ex_ready       execute-side handshake
//   alu_a, alu_b, alu_op      ALU operands and operation
//   ex_pc, ex_store_data      held PC, forwarded rs2 value
//   ex_rd, ex_reg_write       held destination and write enable
// ---------------------------------------------------------------------------
package riscv_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;
endpackage

module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_use_pc,
  input  logic            id_use_imm,
  input  logic            id_reg_write,
  input  alu_op_t         id_alu_op,
  input  logic            flush,
  input  logic            exm_reg_write,
  input  logic [4:0]      exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            mwb_reg_write,
  input  logic [4:0]      mwb_rd,
  input  logic [XLEN-1:0] mwb_result,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output alu_op_t         alu_op,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write
);

  // Held entry
  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [4:0]      rd_q;
  logic            use_pc_q;
  logic            use_imm_q;
  logic            reg_write_q;
  alu_op_t         alu_op_q;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            hazard;
  logic            capture;

`ifdef EX_FWD_EN
  // EX/MEM is the younger producer, so it is checked first. x0 never forwards.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (rs1_q != '0 && exm_reg_write && exm_rd == rs1_q)
      fwd_rs1 = exm_result;
    else if (rs1_q != '0 && mwb_reg_write && mwb_rd == rs1_q)
      fwd_rs1 = mwb_result;

    fwd_rs2 = rs2_data_q;
    if (rs2_q != '0 && exm_reg_write && exm_rd == rs2_q)
      fwd_rs2 = exm_result;
    else if (rs2_q != '0 && mwb_reg_write && mwb_rd == rs2_q)
      fwd_rs2 = mwb_result;
  end

  assign hazard = 1'b0;
`else
  assign fwd_rs1 = rs1_data_q;
  assign fwd_rs2 = rs2_data_q;

  // MEM/WB producers are covered by register-file write-through, so only the
  // held entry and EX/MEM need to stall decode.
  always_comb begin
    hazard = 1'b0;
    if (id_valid) begin
      if (id_rs1 != '0 &&
          ((valid_q && reg_write_q && rd_q == id_rs1) ||
           (exm_reg_write && exm_rd == id_rs1)))
        hazard = 1'b1;
      if (id_rs2 != '0 &&
          ((valid_q && reg_write_q && rd_q == id_rs2) ||
           (exm_reg_write && exm_rd == id_rs2)))
        hazard = 1'b1;
    end
  end

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{mwb_reg_write, mwb_rd, mwb_result, exm_result,
                               rs1_q, rs2_q};
`endif

  assign id_ready = (!valid_q || ex_ready) && !hazard && !flush;
  assign capture  = id_valid && id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      use_pc_q    <= 1'b0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      alu_op_q    <= ALU_ADD;
    end else if (flush) begin
      // Payload is left as-is; only the valid bit is dropped.
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q     <= 1'b1;
      pc_q        <= id_pc;
      imm_q       <= id_imm;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      use_pc_q    <= id_use_pc;
      use_imm_q   <= id_use_imm;
      reg_write_q <= id_reg_write;
      alu_op_q    <= id_alu_op;
    end else if (valid_q && ex_ready) begin
      valid_q <= 1'b0;
    end else if (valid_q) begin
      // Stalled: latch forwarded values so producers that retire during the
      // stall are not lost. Without forwarding this rewrites the same data.
      rs1_data_q <= fwd_rs1;
      rs2_data_q <= fwd_rs2;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rd         = rd_q;
  assign ex_reg_write  = reg_write_q;
  assign alu_op        = alu_op_q;
  assign alu_a         = use_pc_q  ? pc_q  : fwd_rs1;
  assign alu_b         = use_imm_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage : self-checking bench for id_ex_stage. Expected outputs are
// pushed to a scoreboard queue when an instruction is accepted and compared
// when the stage hands it to execute. Forwarding or interlock scenarios are
// selected by EX_FWD_EN to match the build.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_pc, id_use_imm, id_reg_write;
  alu_op_t     id_alu_op;
  logic        flush;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        mwb_reg_write;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_result;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_a, alu_b;
  alu_op_t     alu_op;
  logic [31:0] ex_pc, ex_store_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_pc(id_use_pc), .id_use_imm(id_use_imm),
    .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
    .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_pc(ex_pc), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, imm, d1, d2;
    logic [4:0]  rs1, rs2, rd;
    logic        use_pc, use_imm, rw;
    alu_op_t     op;
  } instr_t;

  typedef struct {
    logic [31:0] a, b, st, pc;
    logic [4:0]  rd;
    logic        rw;
    alu_op_t     op;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic instr_t mk(input int unsigned k, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic up, input logic ui);
    instr_t t;
    t.pc      = 32'h0000_1000 + 32'(k * 4);
    t.imm     = 32'h0000_0100 + 32'(k);
    t.d1      = 32'hA000_0000 | 32'(k);
    t.d2      = 32'hB000_0000 | 32'(k);
    t.rs1     = rs1;
    t.rs2     = rs2;
    t.rd      = rd;
    t.use_pc  = up;
    t.use_imm = ui;
    t.rw      = 1'b1;
    t.op      = alu_op_t'(4'(k % 10));
    return t;
  endfunction

  // Reference model with no active producers.
  function automatic exp_t model(input instr_t t);
    exp_t e;
    e.a  = t.use_pc  ? t.pc  : t.d1;
    e.b  = t.use_imm ? t.imm : t.d2;
    e.st = t.d2;
    e.pc = t.pc;
    e.rd = t.rd;
    e.rw = t.rw;
    e.op = t.op;
    return e;
  endfunction

  task automatic drive(input instr_t t);
    id_valid     = 1'b1;
    id_pc        = t.pc;
    id_imm       = t.imm;
    id_rs1_data  = t.d1;
    id_rs2_data  = t.d2;
    id_rs1       = t.rs1;
    id_rs2       = t.rs2;
    id_rd        = t.rd;
    id_use_pc    = t.use_pc;
    id_use_imm   = t.use_imm;
    id_reg_write = t.rw;
    id_alu_op    = t.op;
  endtask

  // Drive, confirm acceptance, and record the expected result.
  task automatic issue(input string tag, input instr_t t);
    drive(t);
    #1;
    check({tag, "_id_ready"}, 32'(id_ready), 32'd1);
    if (id_ready) sb.push_back(model(t));
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_alu_a"}, alu_a, e.a);
      check({tag, "_alu_b"}, alu_b, e.b);
      check({tag, "_store"}, ex_store_data, e.st);
      check({tag, "_pc"}, ex_pc, e.pc);
      check({tag, "_rd"}, 32'(ex_rd), 32'(e.rd));
      check({tag, "_rw"}, 32'(ex_reg_write), 32'(e.rw));
      check({tag, "_op"}, 32'(alu_op), 32'(e.op));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t t, t2;
    rst = 1'b1; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    id_pc = '0; id_imm = '0; id_rs1_data = '0; id_rs2_data = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_pc = 1'b0; id_use_imm = 1'b0; id_reg_write = 1'b0;
    id_alu_op = ALU_SUB;
    exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
    mwb_reg_write = 1'b0; mwb_rd = '0; mwb_result = '0;

    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_store", ex_store_data, 32'd0);
    check("rst_pc", ex_pc, 32'd0);
    check("rst_rd", 32'(ex_rd), 32'd0);
    check("rst_rw", 32'(ex_reg_write), 32'd0);
    check("rst_op", 32'(alu_op), 32'(ALU_ADD));
    check("rst_id_ready", 32'(id_ready), 32'd1);

    // Throughput: four back-to-back instructions
    ex_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 4) begin
        check("tp_valid", 32'(ex_valid), 32'd1);
        pop_check("tp");
      end
      if (i == 5) check("tp_drain_valid", 32'(ex_valid), 32'd0);
      if (i < 4)
        issue("tp", mk(32'(i), 5'(10 + i), 5'(20 + i), 5'(1 + i),
                       1'(i % 2), 1'(i / 2)));
      else
        id_valid = 1'b0;
    end

    // Stall: entry held while ex_ready is low
    @(negedge clk);
    ex_ready = 1'b0;
    issue("st", mk(32'd7, 5'd11, 5'd12, 5'd9, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      id_valid = 1'b0;
      #1;
      check("st_valid", 32'(ex_valid), 32'd1);
      check("st_pc", ex_pc, 32'h0000_101C);
      check("st_id_ready", 32'(id_ready), 32'd0);
    end
    @(negedge clk);
    ex_ready = 1'b1;
    #1;
    check("st_out_valid", 32'(ex_valid), 32'd1);
    pop_check("st");
    @(negedge clk);
    check("st_done_valid", 32'(ex_valid), 32'd0);

    // Flush: dominates id_valid and ex_ready, incoming not captured
    ex_ready = 1'b0;
    t = mk(32'd20, 5'd13, 5'd14, 5'd15, 1'b0, 1'b0);
    issue("fl", t);
    @(negedge clk);
    t2 = mk(32'd21, 5'd16, 5'd17, 5'd18, 1'b1, 1'b1);
    drive(t2);
    flush = 1'b1;
    ex_ready = 1'b1;
    #1;
    check("fl_id_ready", 32'(id_ready), 32'd0);
    check("fl_valid_before", 32'(ex_valid), 32'd1);
    sb.delete();
    @(negedge clk);
    flush = 1'b0;
    id_valid = 1'b0;
    #1;
    check("fl_valid_after", 32'(ex_valid), 32'd0);
    check("fl_pc_held", ex_pc, t.pc);
    check("fl_id_ready_after", 32'(id_ready), 32'd1);

    // Reset while stalled drops the entry
    @(negedge clk);
    ex_ready = 1'b0;
    issue("rs", mk(32'd30, 5'd19, 5'd21, 5'd22, 1'b1, 1'b0));
    @(negedge clk);
    id_valid = 1'b0;
    check("rs_held", 32'(ex_valid), 32'd1);
    rst = 1'b1;
    ex_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ex_ready = 1'b0;
    #1;
    check("rs_valid", 32'(ex_valid), 32'd0);
    check("rs_pc", ex_pc, 32'd0);
    check("rs_alu_a", alu_a, 32'd0);
    check("rs_op", 32'(alu_op), 32'(ALU_ADD));
    sb.delete();

`ifdef EX_FWD_EN
    // Forwarding priority on rs1, then stall refresh on rs2
    @(negedge clk);
    t = mk(32'd40, 5'd5, 5'd7, 5'd20, 1'b0, 1'b0);
    t.d1 = 32'h11;
    t.d2 = 32'h44;
    issue("fw", t);
    sb.delete();
    @(negedge clk);
    id_valid = 1'b0;
    exm_reg_write = 1'b1; exm_rd = 5'd5; exm_result = 32'h22;
    mwb_reg_write = 1'b1; mwb_rd = 5'd5; mwb_result = 32'h33;
    #1;
    check("fw_exm", alu_a, 32'h22);
    exm_reg_write = 1'b0;
    #1;
    check("fw_mwb", alu_a, 32'h33);
    mwb_reg_write = 1'b0;
    #1;
    check("fw_none", alu_a, 32'h11);
    check("fw_b_none", alu_b, 32'h44);
    exm_reg_write = 1'b1; exm_rd = 5'd7; exm_result = 32'hAB;
    #1;
    check("fw_b_exm", alu_b, 32'hAB);
    @(negedge clk);
    exm_reg_write = 1'b0;
    #1;
    check("rf_alu_b", alu_b, 32'hAB);
    check("rf_store", ex_store_data, 32'hAB);
    check("rf_alu_a", alu_a, 32'h11);
    ex_ready = 1'b1;
    #1;
    check("rf_out_valid", 32'(ex_valid), 32'd1);
    check("rf_out_b", alu_b, 32'hAB);
    @(negedge clk);
    ex_ready = 1'b0;
    check("rf_done_valid", 32'(ex_valid), 32'd0);

    // x0 never forwards and is never refreshed
    t = mk(32'd41, 5'd0, 5'd0, 5'd21, 1'b0, 1'b0);
    t.d1 = 32'h11;
    t.d2 = 32'h55;
    issue("x0", t);
    sb.delete();
    @(negedge clk);
    id_valid = 1'b0;
    exm_reg_write = 1'b1; exm_rd = 5'd0; exm_result = 32'h22;
    mwb_reg_write = 1'b1; mwb_rd = 5'd0; mwb_result = 32'h33;
    #1;
    check("x0_alu_a", alu_a, 32'h11);
    check("x0_store", ex_store_data, 32'h55);
    @(negedge clk);
    exm_reg_write = 1'b0;
    mwb_reg_write = 1'b0;
    #1;
    check("x0_held_a", alu_a, 32'h11);
    check("x0_held_b", alu_b, 32'h55);
    ex_ready = 1'b1;
    @(negedge clk);
    ex_ready = 1'b0;
    check("x0_done_valid", 32'(ex_valid), 32'd0);
`else
    // Interlock on held rd, then on EX/MEM rd
    @(negedge clk);
    ex_ready = 1'b0;
    t = mk(32'd50, 5'd13, 5'd14, 5'd3, 1'b0, 1'b0);
    issue("ik", t);
    @(negedge clk);
    drive(mk(32'd51, 5'd3, 5'd15, 5'd16, 1'b0, 1'b1));
    #1;
    check("ik_held_rd", 32'(id_ready), 32'd0);
    @(negedge clk);
    ex_ready = 1'b1;
    #1;
    check("ik_held_rd_ready", 32'(id_ready), 32'd0);
    pop_check("ik");
    @(negedge clk);
    exm_reg_write = 1'b1;
    exm_rd = 5'd3;
    #1;
    check("ik_exm_empty", 32'(ex_valid), 32'd0);
    check("ik_exm_rd", 32'(id_ready), 32'd0);
    @(negedge clk);
    exm_reg_write = 1'b0;
    issue("ik2", mk(32'd51, 5'd3, 5'd15, 5'd16, 1'b0, 1'b1));
    @(negedge clk);
    id_valid = 1'b0;
    check("ik2_valid", 32'(ex_valid), 32'd1);
    pop_check("ik2");
    @(negedge clk);
    check("ik2_done_valid", 32'(ex_valid), 32'd0);
`endif

    @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 supported.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 id_valid / id_ready  input / output  1 / 1  decode-side handshake.
REQ-005 id_pc, id_imm, id_rs1_data, id_rs2_data  input  32 each  decoded PC, immediate, register-file read data.
REQ-006 id_rs1, id_rs2, id_rd  input  5 each  source and destination register indices.
REQ-007 id_use_pc, id_use_imm, id_reg_write  input  1 each  A-operand = PC, B-operand = immediate, instruction writes rd.
REQ-008 id_alu_op  input  alu_op_t  ALU operation from riscv_pkg.
REQ-009 flush  input  1  discard held entry (branch redirect).
REQ-010 exm_reg_write, exm_rd, exm_result  input  1/5/32  EX/MEM producer.
REQ-011 mwb_reg_write, mwb_rd, mwb_result  input  1/5/32  MEM/WB producer.
REQ-012 ex_valid / ex_ready  output / input  1 / 1  execute-side handshake.
REQ-013 alu_a, alu_b  output  32 each  ALU operands; alu_op  output  alu_op_t.
REQ-014 ex_pc, ex_store_data  output  32 each; ex_rd  output  5; ex_reg_write  output  1.

Function
REQ-015 Block shall hold one entry: pc, imm, rs1/rs2 index and data, rd, use_pc, use_imm, reg_write, alu_op, valid.
REQ-016 id_ready shall equal (!ex_valid || ex_ready) && !hazard && !flush; hazard defined in Configuration.
REQ-017 On id_valid && id_ready entry shall load decode inputs and ex_valid shall be 1 next cycle (latency 1).
REQ-018 On ex_valid && ex_ready without capture, ex_valid shall be 0 next cycle; back-to-back capture and consume shall sustain one instruction per cycle.
REQ-019 fwd(idx,data): exm_result if exm_reg_write && exm_rd==idx && idx!=0; else mwb_result if mwb_reg_write && mwb_rd==idx && idx!=0; else data (EX/MEM has priority).
REQ-020 alu_a = use_pc ? ex_pc : fwd(rs1); alu_b = use_imm ? imm : fwd(rs2); ex_store_data = fwd(rs2); all combinational from held entry.
REQ-021 While ex_valid && !ex_ready, stored rs1/rs2 data shall be overwritten each cycle with fwd values so producers retiring during the stall are not lost.
REQ-022 Index 0 shall never forward; stored data for x0 remains as read.
REQ-023 flush shall clear ex_valid next cycle and block capture that cycle; flush dominates id_valid and ex_ready.
REQ-024 Payload registers shall hold value when ex_valid=0; consumers shall qualify with ex_valid.

Reset
REQ-025 rst shall dominate flush and handshakes; next cycle ex_valid=0, ex_reg_write=0, ex_rd=0, pc/imm/data=0, alu_op=ALU_ADD, use_pc=use_imm=0.
REQ-026 Hence after reset alu_a=alu_b=ex_store_data=0, ex_pc=0; id_ready=1 once rst deasserts.
REQ-027 rst mid-stall shall drop the held entry with no output handshake.

Configuration
REQ-028 Macro EX_FWD_EN defined: REQ-019..021 active; hazard = 0.
REQ-029 EX_FWD_EN undefined: fwd(idx,data)=data, no refresh; hazard = id_valid && any nonzero id_rs1/id_rs2 equal to (held entry rd if ex_valid && reg_write) or (exm_rd if exm_reg_write); MWB covered by register-file write-through.

Verification
REQ-030 Reset: assert rst 2 cycles -> ex_valid=0, alu_a=alu_b=0, alu_op=ALU_ADD, id_ready=1.
REQ-031 Throughput: 4 instructions, id_valid=1, ex_ready=1 -> ex_valid continuous from cycle 1, one per cycle, order preserved.
REQ-032 Forward (EX_FWD_EN): held rs1=5, data 0x11; exm_rd=5 result 0x22, mwb_rd=5 result 0x33 -> alu_a=0x22; exm off -> 0x33; rd=0 match -> 0x11.
REQ-033 Stall refresh: ex_ready=0, exm_rd=7 result 0xAB for one cycle then exm idle; held rs2=7 -> alu_b=0xAB when ex_ready rises.
REQ-034 Flush: ex_valid=1, flush=1 with id_valid=1 -> ex_valid=0 next cycle, incoming instruction not captured.
REQ-035 Interlock (no EX_FWD_EN): held rd=3 reg_write, id_rs1=3 -> id_ready=0 until producer clears exm stage.
